// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// General-purpose register file with two write ports and a load-pending
// scoreboard. Register 0 is hard-wired to zero and can never be busy.
//
// Port A (ALU) and port B (load unit) both write on the rising edge. Port B
// wins when both target the same register. A port B write also clears that
// register's busy bit, which decode sets with a reserve request.
//
// Handshake: the reserve port has no ready/valid pair. i_rsv_en is a request,
// and o_rsv_ack is a combinational accept in the same cycle. A rejected
// request changes nothing; decode simply retries.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_rd_addr1/2                read addresses (combinational reads)
//   o_rd_data1/2                read data (optionally bypassed from writes)
//   o_rd_busy1/2                addressed register has a load pending
//   i_wa_en/addr/data           write port A (ALU)
//   i_wb_en/addr/data           write port B (load writeback, clears busy)
//   i_rsv_en/addr, o_rsv_ack    reserve request / same-cycle accept
//   o_busy_count                number of busy registers
//   o_wr_collide                A and B wrote the same nonzero register in
//                               the previous cycle
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wa_en,
    input  logic [ADDR_W-1:0] i_wa_addr,
    input  logic [DATA_W-1:0] i_wa_data,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic              o_rsv_ack,
    output logic [ADDR_W:0]   o_busy_count,
    output logic              o_wr_collide
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;
    logic              r_wr_collide;

    logic              w_wa_hit;
    logic              w_wb_hit;
    logic              w_rsv_set;
    logic              w_wb_clr;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    logic              w_rd_busy1;
    logic              w_rd_busy2;

    // Writes to register 0 are discarded, so only nonzero addresses count.
    assign w_wa_hit = i_wa_en && (i_wa_addr != '0);
    assign w_wb_hit = i_wb_en && (i_wb_addr != '0);

    // Reserve to register 0 is acknowledged but does not change any state.
    assign o_rsv_ack = i_rsv_en && ((i_rsv_addr == '0) || !r_busy[i_rsv_addr]);
    assign w_rsv_set = o_rsv_ack && (i_rsv_addr != '0);

    // Only a set bit is counted as a clear. A reserve and a port B write to the
    // same register can never both take effect: the reserve is rejected
    // because the bit is already set.
    assign w_wb_clr  = w_wb_hit && r_busy[i_wb_addr];

    // Register array. Port B has priority over port A.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wb_hit) begin
                r_regs[i_wb_addr] <= i_wb_data;
            end
            if (w_wa_hit && !(w_wb_hit && (i_wb_addr == i_wa_addr))) begin
                r_regs[i_wa_addr] <= i_wa_data;
            end
        end
    end

    // Scoreboard. Port A writes leave busy bits untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wb_clr) begin
                r_busy[i_wb_addr] <= 1'b0;
            end
            if (w_rsv_set) begin
                r_busy[i_rsv_addr] <= 1'b1;
            end
            // Net update: a set and a clear in the same cycle cancel out.
            if (w_rsv_set && !w_wb_clr) begin
                r_busy_count <= r_busy_count + 1'b1;
            end else if (w_wb_clr && !w_rsv_set) begin
                r_busy_count <= r_busy_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_collide <= 1'b0;
        end else begin
            r_wr_collide <= w_wa_hit && w_wb_hit && (i_wa_addr == i_wb_addr);
        end
    end

    // Read muxes. With bypass, a write in the current cycle is forwarded to the
    // read port, and a load write also hides the busy bit it is about to clear.
    always_comb begin
        w_rd_data1 = r_regs[i_rd_addr1];
        w_rd_busy1 = r_busy[i_rd_addr1];
        if (i_rd_addr1 == '0) begin
            w_rd_data1 = '0;
            w_rd_busy1 = 1'b0;
        end else if (BYPASS && w_wb_hit && (i_wb_addr == i_rd_addr1)) begin
            w_rd_data1 = i_wb_data;
            w_rd_busy1 = 1'b0;
        end else if (BYPASS && w_wa_hit && (i_wa_addr == i_rd_addr1)) begin
            w_rd_data1 = i_wa_data;
        end
    end

    always_comb begin
        w_rd_data2 = r_regs[i_rd_addr2];
        w_rd_busy2 = r_busy[i_rd_addr2];
        if (i_rd_addr2 == '0) begin
            w_rd_data2 = '0;
            w_rd_busy2 = 1'b0;
        end else if (BYPASS && w_wb_hit && (i_wb_addr == i_rd_addr2)) begin
            w_rd_data2 = i_wb_data;
            w_rd_busy2 = 1'b0;
        end else if (BYPASS && w_wa_hit && (i_wa_addr == i_rd_addr2)) begin
            w_rd_data2 = i_wa_data;
        end
    end

    assign o_rd_data1   = w_rd_data1;
    assign o_rd_data2   = w_rd_data2;
    assign o_rd_busy1   = w_rd_busy1;
    assign o_rd_busy2   = w_rd_busy2;
    assign o_busy_count = r_busy_count;
    assign o_wr_collide = r_wr_collide;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed test of reg_file_sb (DATA_W=8, ADDR_W=3, BYPASS=1). Each expected
// value below is written out by hand from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ack;
    logic [ADDR_W:0]   busy_count;
    logic              wr_collide;

    int n_checks;
    int n_fails;

    reg_file_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BYPASS(1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rd_addr1   (rd_addr1),
        .i_rd_addr2   (rd_addr2),
        .o_rd_data1   (rd_data1),
        .o_rd_data2   (rd_data2),
        .o_rd_busy1   (rd_busy1),
        .o_rd_busy2   (rd_busy2),
        .i_wa_en      (wa_en),
        .i_wa_addr    (wa_addr),
        .i_wa_data    (wa_data),
        .i_wb_en      (wb_en),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .i_rsv_en     (rsv_en),
        .i_rsv_addr   (rsv_addr),
        .o_rsv_ack    (rsv_ack),
        .o_busy_count (busy_count),
        .o_wr_collide (wr_collide)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic drive_wa(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wa_en = 1'b1; wa_addr = a; wa_data = d;
    endtask

    task automatic drive_wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic drive_rsv(input logic [ADDR_W-1:0] a);
        rsv_en = 1'b1; rsv_addr = a;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        rd_addr1 = '0;
        rd_addr2 = '0;
        rst_n    = 1'b0;
        #2;

        // Reset state: every address reads zero and is not busy.
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = ADDR_W'(i);
            rd_addr2 = ADDR_W'(7 - i);
            #1;
            check("rst_data1", rd_data1, 0);
            check("rst_data2", rd_data2, 0);
            check("rst_busy1", rd_busy1, 0);
            check("rst_busy2", rd_busy2, 0);
        end
        check("rst_count", busy_count, 0);
        check("rst_collide", wr_collide, 0);
        check("rst_ack_idle", rsv_ack, 0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Port A write to 3, bypassed in the same cycle, stored afterwards.
        drive_wa(3'd3, 8'h5A);
        rd_addr1 = 3'd3;
        #1;
        check("wa3_bypass", rd_data1, 8'h5A);
        tick();
        idle();
        #1;
        check("wa3_stored", rd_data1, 8'h5A);

        // Write to register 0 is discarded and never forwarded.
        drive_wa(3'd0, 8'hFF);
        rd_addr1 = 3'd0;
        #1;
        check("wa0_bypass", rd_data1, 0);
        tick();
        idle();
        #1;
        check("wa0_stored", rd_data1, 0);

        // Collision on 5: port B wins, flag one cycle later for one cycle.
        drive_wa(3'd5, 8'h11);
        drive_wb(3'd5, 8'h22);
        rd_addr1 = 3'd5;
        #1;
        check("col_bypass", rd_data1, 8'h22);
        check("col_flag_pre", wr_collide, 0);
        tick();
        idle();
        #1;
        check("col_stored", rd_data1, 8'h22);
        check("col_flag", wr_collide, 1);
        tick();
        check("col_flag_drop", wr_collide, 0);

        // Different addresses on A and B: both forwarded, no collision.
        drive_wa(3'd6, 8'h33);
        drive_wb(3'd7, 8'h44);
        rd_addr1 = 3'd6;
        rd_addr2 = 3'd7;
        #1;
        check("ab_bypass_a", rd_data1, 8'h33);
        check("ab_bypass_b", rd_data2, 8'h44);
        tick();
        idle();
        #1;
        check("ab_stored_a", rd_data1, 8'h33);
        check("ab_stored_b", rd_data2, 8'h44);
        check("ab_no_collide", wr_collide, 0);

        // Reserve 4, re-reserve rejected, load writeback clears it.
        drive_rsv(3'd4);
        rd_addr1 = 3'd4;
        #1;
        check("rsv4_ack", rsv_ack, 1);
        check("rsv4_busy_pre", rd_busy1, 0);
        tick();
        #1;
        check("rsv4_busy", rd_busy1, 1);
        check("rsv4_count", busy_count, 1);
        check("rsv4_again_ack", rsv_ack, 0);
        tick();
        idle();
        #1;
        check("rsv4_again_count", busy_count, 1);
        drive_wb(3'd4, 8'h77);
        #1;
        check("wb4_bypass_busy", rd_busy1, 0);
        check("wb4_bypass_data", rd_data1, 8'h77);
        tick();
        idle();
        #1;
        check("wb4_busy", rd_busy1, 0);
        check("wb4_count", busy_count, 0);
        check("wb4_data", rd_data1, 8'h77);

        // Port A write to a busy register keeps it busy.
        drive_rsv(3'd1);
        tick();
        idle();
        drive_wa(3'd1, 8'h99);
        rd_addr1 = 3'd1;
        #1;
        check("wa_busy_bypass_busy", rd_busy1, 1);
        tick();
        idle();
        #1;
        check("wa_busy_data", rd_data1, 8'h99);
        check("wa_busy_busy", rd_busy1, 1);
        check("wa_busy_count", busy_count, 1);

        // Reserve 2, then reserve 2 while load writes 2: rejected, bit cleared.
        drive_rsv(3'd2);
        tick();
        idle();
        #1;
        check("rsv2_count", busy_count, 2);
        drive_rsv(3'd2);
        drive_wb(3'd2, 8'h12);
        rd_addr2 = 3'd2;
        #1;
        check("rsv2_wb_ack", rsv_ack, 0);
        tick();
        idle();
        #1;
        check("rsv2_wb_busy", rd_busy2, 0);
        check("rsv2_wb_count", busy_count, 1);
        check("rsv2_wb_data", rd_data2, 8'h12);

        // Reserve 6 while load clears 1: count stays at 1.
        drive_rsv(3'd6);
        drive_wb(3'd1, 8'h55);
        #1;
        check("rsv6_ack", rsv_ack, 1);
        tick();
        idle();
        rd_addr1 = 3'd6;
        rd_addr2 = 3'd1;
        #1;
        check("net_count", busy_count, 1);
        check("net_busy6", rd_busy1, 1);
        check("net_busy1", rd_busy2, 0);
        check("net_data1", rd_data2, 8'h55);

        // Reserve to 0: accepted, no state change.
        drive_rsv(3'd0);
        rd_addr1 = 3'd0;
        #1;
        check("rsv0_ack", rsv_ack, 1);
        tick();
        idle();
        #1;
        check("rsv0_count", busy_count, 1);
        check("rsv0_busy", rd_busy1, 0);

        // Reserve 1, 2, 3 (plus collision on 5), then reset mid-cycle.
        drive_rsv(3'd1);
        tick();
        drive_rsv(3'd2);
        tick();
        drive_rsv(3'd3);
        drive_wa(3'd5, 8'hA1);
        drive_wb(3'd5, 8'hB2);
        tick();
        idle();
        rd_addr1 = 3'd3;
        rd_addr2 = 3'd5;
        #1;
        check("pre_rst_count", busy_count, 4);
        check("pre_rst_collide", wr_collide, 1);
        check("pre_rst_busy3", rd_busy1, 1);
        check("pre_rst_data5", rd_data2, 8'hB2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", busy_count, 0);
        check("mid_rst_collide", wr_collide, 0);
        check("mid_rst_data3", rd_data1, 0);
        check("mid_rst_busy3", rd_busy1, 0);
        check("mid_rst_data5", rd_data2, 0);
        rd_addr1 = 3'd6;
        rd_addr2 = 3'd4;
        #1;
        check("mid_rst_busy6", rd_busy1, 0);
        check("mid_rst_data4", rd_data2, 0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_count", busy_count, 0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected end by 20000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised dual-write register file with a load-pending scoreboard, the next-generation general-purpose register file for the datapath. It keeps register 0 hard-wired to zero and adds a second write port for load writeback, optional write-to-read bypass, per-register busy bits set by a reserve request, and a busy-register counter. It sits between decode, which reads and reserves registers, and the two writeback sources: ALU on port A, load unit on port B.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data
- rd_busy1, rd_busy2  out  1  addressed register has a load pending
- wa_en  in  1  port A (ALU) write enable
- wa_addr  in  ADDR_W  port A address
- wa_data  in  DATA_W  port A data
- wb_en  in  1  port B (load) write enable
- wb_addr  in  ADDR_W  port B address
- wb_data  in  DATA_W  port B data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ack  out  1  reserve accepted this cycle
- busy_count  out  ADDR_W+1  number of busy registers
- wr_collide  out  1  registered flag: ports A and B wrote the same nonzero address in the previous cycle

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_count 0, wr_collide 0. Outputs: rd_data* reflect zeros, rd_busy* 0, rsv_ack follows its combinational rule.
- Register 0: always reads 0, never busy; writes to it are discarded; rsv to 0 gives rsv_ack=1 with no state change.
- Writes: on posedge, wa_en writes wa_data to wa_addr, wb_en writes wb_data to wb_addr. Same nonzero address on both: port B wins, wr_collide=1 the following cycle (held for one cycle unless the collision repeats).
- Port A writing a busy register: data written, busy bit unchanged.
- Port B write to a nonzero address clears its busy bit (if set); busy_count decrements only when the bit was set.
- Reserve: rsv_ack = rsv_en && (rsv_addr==0 || !busy[rsv_addr]), combinational. Accepted reserve of a nonzero address sets busy at posedge and increments busy_count. Rejected reserve: no state change.
- Same-cycle reserve and port B write to the same nonzero address: busy is busy before the edge, so rsv_ack=0; the write clears the bit. Decode retries the next cycle.
- busy_count never exceeds DEPTH-1. It is net-updated per cycle: +1 on accepted reserve, -1 on a clear of a set bit; both in the same cycle leave it unchanged.
- Bypass (BYPASS=1): for a nonzero read address matching an enabled write this cycle, rd_data returns the write data, port B over port A. rd_busy is 0 if port B is writing that address.
- BYPASS=0: rd_data and rd_busy reflect the pre-edge state only.

## Timing
- Reads, rd_busy and rsv_ack: combinational, zero latency.
- Write data visible at read ports one cycle after the write edge (same cycle with BYPASS=1).
- Busy set and clear take effect at the posedge of the accepting cycle.
- wr_collide: 1-cycle latency after the colliding edge.
- Reset asserted mid-operation: all state clears immediately; pending loads are forgotten.

## Test plan
- Reset, then read all addresses -> all rd_data 0, rd_busy 0, busy_count 0.
- wa_en=1 addr 3 data 0x5A; next cycle read 3 -> 0x5A. Write 0xFF to addr 0 -> reads 0.
- Same cycle wa (addr 5, 0x11) and wb (addr 5, 0x22) -> reg5=0x22, wr_collide=1 for one cycle. With BYPASS=1, a same-cycle read of 5 returns 0x22.
- Reserve addr 4 -> rsv_ack=1, next cycle rd_busy=1 and busy_count=1. Second reserve of 4 -> rsv_ack=0. wb addr 4 data 0x77 -> busy clears, busy_count=0, reads 0x77.
- Reserve 2 while wb writes 2 (which was busy) -> rsv_ack=0, busy=0 after the edge. Reserve 6 and clear busy 1 in the same cycle -> busy_count unchanged.
- Reserve 1, 2 and 3, then assert rst_n low mid-cycle -> busy_count and all registers 0 immediately, without waiting for a clock edge.
